apb_master_bridge: RTL and testbench



---
 rtl/apb_pkg.sv | 11 +
 rtl/apb_slave_mux.sv | 31 +++
 rtl/apb_master_bridge.sv | 122 ++++++++++++
 tb/tb_apb_master_bridge.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB master bridge.
//   apb_state_t   - bridge FSM states
//   APB_DATA_W    - APB data bus width
//   APB_IDX_W     - slave index width
//   APB_ERR_RDATA - read data returned on any error
package apb_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
   localparam int APB_DATA_W = 32;
   localparam int APB_IDX_W = 4;
   localparam logic [APB_DATA_W-1:0] APB_ERR_RDATA = 32'h0;
endpackage

// File: rtl/apb_slave_mux.sv
// apb_slave_mux: picks the selected slave's PREADY, PRDATA and PSLVERROR.
//   i_idx     - registered slave index
//   i_pready  - per-slave ready
//   i_prdata  - per-slave read data, slave i at [32i+31:32i]
//   i_pslverr - per-slave error
//   o_*       - the selected slave's signals (all 0 if the index is unmapped)
module apb_slave_mux
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES = 8
) (
   input  logic [APB_IDX_W-1:0]             i_idx,
   input  logic [NUM_SLAVES-1:0]            i_pready,
   input  logic [NUM_SLAVES*APB_DATA_W-1:0] i_prdata,
   input  logic [NUM_SLAVES-1:0]            i_pslverr,
   output logic                             o_pready,
   output logic [APB_DATA_W-1:0]            o_prdata,
   output logic                             o_pslverr
);
   always_comb begin
      o_pready = 1'b0;
      o_prdata = '0;
      o_pslverr = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (int'(i_idx) == i) begin
            o_pready = i_pready[i];
            o_prdata = i_prdata[i*APB_DATA_W +: APB_DATA_W];
            o_pslverr = i_pslverr[i];
         end
   end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command port to a single-initiator APB bus.
//   io_apb_PCLK/io_apb_PRESET - clock, async active-high reset
//   cmd_*                     - command request (write, addr, wdata)
//   rsp_*                     - held response (rdata, error)
//   io_apb_P*                 - APB master signals, one-hot PSEL per slave
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES = 8,
   parameter int SLAVE_ADDR_BITS = 12,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                             io_apb_PCLK,
   input  logic                             io_apb_PRESET,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_write,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr,
   input  logic [APB_DATA_W-1:0]            cmd_wdata,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [APB_DATA_W-1:0]            rsp_rdata,
   output logic                             rsp_error,
   output logic [SLAVE_ADDR_BITS-1:0]       io_apb_PADDR,
   output logic [NUM_SLAVES-1:0]            io_apb_PSEL,
   output logic                             io_apb_PENABLE,
   output logic                             io_apb_PWRITE,
   output logic [APB_DATA_W-1:0]            io_apb_PWDATA,
   input  logic [NUM_SLAVES-1:0]            io_apb_PREADY,
   input  logic [NUM_SLAVES*APB_DATA_W-1:0] io_apb_PRDATA,
   input  logic [NUM_SLAVES-1:0]            io_apb_PSLVERROR
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   apb_state_t r_state, w_next;
   logic r_live, r_write, r_error;
   logic [SLAVE_ADDR_BITS-1:0] r_addr;
   logic [APB_DATA_W-1:0] r_wdata, r_rdata, w_rdata;
   logic [APB_IDX_W-1:0] r_idx, w_cmd_idx;
   logic [CNT_W-1:0] r_cnt;
   logic w_ready, w_err, w_unmapped, w_tmo, w_accept, w_done;
   logic [NUM_SLAVES-1:0] w_sel;
   assign w_cmd_idx = cmd_addr[ADDR_WIDTH-1:SLAVE_ADDR_BITS];
   assign w_unmapped = int'(w_cmd_idx) >= NUM_SLAVES;
   assign w_sel = NUM_SLAVES'(1) << r_idx;
   // r_cnt holds the number of ACCESS cycles already spent waiting, so the
   // last permitted wait cycle is the one where it equals TIMEOUT-1
   assign w_tmo = (TIMEOUT != 0) && (int'(r_cnt) == TIMEOUT - 1);
   assign w_accept = r_state == IDLE && r_live && cmd_valid;
   assign w_done = r_state == ACCESS && (w_ready || w_tmo);
   assign io_apb_PADDR = r_addr;
   assign io_apb_PWRITE = r_write;
   assign io_apb_PWDATA = r_wdata;
   assign rsp_rdata = r_rdata;
   assign rsp_error = r_error;
   apb_slave_mux #(.NUM_SLAVES(NUM_SLAVES)) u_mux (
      .i_idx(r_idx),
      .i_pready(io_apb_PREADY),
      .i_prdata(io_apb_PRDATA),
      .i_pslverr(io_apb_PSLVERROR),
      .o_pready(w_ready),
      .o_prdata(w_rdata),
      .o_pslverr(w_err)
   );
   always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET)
      if (io_apb_PRESET) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      io_apb_PSEL = '0;
      io_apb_PENABLE = 1'b0;
      unique case (r_state)
         IDLE: begin
            cmd_ready = r_live;
            if (w_accept) w_next = w_unmapped ? RESP : SETUP;
         end
         SETUP: begin
            io_apb_PSEL = w_sel;
            w_next = ACCESS;
         end
         ACCESS: begin
            io_apb_PSEL = w_sel;
            io_apb_PENABLE = 1'b1;
            if (w_ready || w_tmo) w_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next = IDLE;
         end
      endcase
   end
   // r_live keeps cmd_ready low until the first edge after reset release
   always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET)
      if (io_apb_PRESET) begin
         r_live <= 1'b0;
         r_write <= 1'b0;
         r_addr <= '0;
         r_wdata <= '0;
         r_idx <= '0;
         r_rdata <= '0;
         r_error <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_live <= 1'b1;
         r_cnt <= (r_state == ACCESS) ? r_cnt + 1'b1 : '0;
         if (w_accept) begin
            r_write <= cmd_write;
            r_addr <= cmd_addr[SLAVE_ADDR_BITS-1:0];
            r_wdata <= cmd_wdata;
            r_idx <= w_cmd_idx;
            r_error <= w_unmapped;
            r_rdata <= APB_ERR_RDATA;
         end
         // a PREADY in the final wait cycle takes precedence over the timeout
         if (w_done) begin
            r_error <= w_ready ? w_err : 1'b1;
            r_rdata <= (w_ready && !r_write && !w_err) ? w_rdata : APB_ERR_RDATA;
         end
      end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed and random transfers checked against a transaction-level model.
module tb_apb_master_bridge;
   localparam int NS = 6;
   localparam int TMO = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [15:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic rsp_valid, rsp_ready = 1'b0, rsp_error;
   logic [31:0] rsp_rdata, pwdata;
   logic [11:0] paddr;
   logic [NS-1:0] psel, pready = '0, pslverr = '0;
   logic penable, pwrite;
   logic [NS*32-1:0] prdata = '0;
   int compared = 0, mismatched = 0;

   apb_master_bridge #(.NUM_SLAVES(NS), .SLAVE_ADDR_BITS(12), .ADDR_WIDTH(16), .TIMEOUT(TMO)) dut (
      .io_apb_PCLK(clk), .io_apb_PRESET(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .io_apb_PADDR(paddr), .io_apb_PSEL(psel), .io_apb_PENABLE(penable),
      .io_apb_PWRITE(pwrite), .io_apb_PWDATA(pwdata),
      .io_apb_PREADY(pready), .io_apb_PRDATA(prdata), .io_apb_PSLVERROR(pslverr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transaction-level expectation: unmapped -> immediate error, waits reaching
   // the timeout -> error after TMO ACCESS cycles, else the slave's answer.
   task automatic model(input bit wr, input logic [15:0] addr, input int waits, input logic [31:0] d,
                        input bit e, output bit xe, output logic [31:0] xr, output int xa);
      if (int'(addr[15:12]) >= NS) begin xe = 1; xr = 0; xa = 0; end
      else if (TMO != 0 && waits >= TMO) begin xe = 1; xr = 0; xa = TMO; end
      else begin xe = e; xr = (!wr && !e) ? d : 32'h0; xa = waits + 1; end
   endtask

   task automatic drive_slaves(input int idx, input bit rdy, input logic [31:0] d, input bit e);
      for (int i = 0; i < NS; i++) begin
         pready[i] = (i == idx) ? rdy : 1'($urandom);
         pslverr[i] = (i == idx) ? e : 1'($urandom);
         prdata[i*32 +: 32] = (i == idx) ? d : $urandom;
      end
   endtask

   task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wd, input int waits,
                          input logic [31:0] d, input bit e, input int hold);
      bit xe;
      logic [31:0] xr;
      logic [NS-1:0] one, xsel;
      int xa, idx, acc, guard;
      model(wr, addr, waits, d, e, xe, xr, xa);
      idx = int'(addr[15:12]);
      one = 1;
      xsel = one << idx;
      guard = 0;
      while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      @(negedge clk);
      cmd_valid = 1'($urandom); cmd_addr = 16'($urandom); cmd_write = 1'($urandom);
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (idx >= NS) begin
         chk("unmapped_psel", 32'(psel), 32'd0);
      end else begin
         chk("setup_psel", 32'(psel), 32'(xsel));
         chk("setup_penable", 32'(penable), 32'd0);
         chk("setup_paddr", 32'(paddr), 32'(addr[11:0]));
         chk("setup_pwrite", 32'(pwrite), 32'(wr));
         if (wr) chk("setup_pwdata", pwdata, wd);
         drive_slaves(idx, 1'($urandom), d, e);
         acc = 0;
         @(negedge clk);
         while (!rsp_valid && acc < 40) begin
            acc++;
            chk("access_psel", 32'(psel), 32'(xsel));
            chk("access_penable", 32'(penable), 32'd1);
            chk("access_paddr", 32'(paddr), 32'(addr[11:0]));
            drive_slaves(idx, acc > waits, d, e);
            @(negedge clk);
         end
         chk("access_cycles", 32'(acc), 32'(xa));
      end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_psel", 32'(psel), 32'd0);
      chk("rsp_penable", 32'(penable), 32'd0);
      chk("rsp_error", 32'(rsp_error), 32'(xe));
      chk("rsp_rdata", rsp_rdata, xr);
      for (int h = 0; h < hold; h++) begin
         cmd_valid = 1'b1; cmd_addr = 16'($urandom);
         drive_slaves(-1, 0, 0, 0);
         @(negedge clk);
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("hold_rsp_error", 32'(rsp_error), 32'(xe));
         chk("hold_rsp_rdata", rsp_rdata, xr);
      end
      rsp_ready = 1'b1; cmd_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      @(negedge clk);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset_psel", 32'(psel), 32'd0);
      chk("reset_penable", 32'(penable), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_error", 32'(rsp_error), 32'd0);
      chk("reset_paddr", 32'(paddr), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("first_cmd_ready", 32'(cmd_ready), 32'd1);
      run_txn(1, 16'h1014, 32'hA5A5_0001, 0, 32'hFFFF_FFFF, 0, 0);
      run_txn(0, 16'h5ABC, 32'h0, 3, 32'h1234_5678, 0, 1);
      run_txn(0, 16'h7000, 32'h0, 0, 32'h1111_1111, 0, 0);
      run_txn(0, 16'h2008, 32'h0, 1000, 32'h2222_2222, 0, 0);
      run_txn(0, 16'h3010, 32'h0, TMO - 1, 32'hCAFE_F00D, 0, 0);
      run_txn(0, 16'h4000, 32'h0, 2, 32'hDEAD_BEEF, 1, 0);
      run_txn(1, 16'h0FFC, 32'h0BAD_CAFE, 1, 32'h5555_AAAA, 0, 5);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h2040; cmd_wdata = 32'h7777_7777;
      @(negedge clk);
      cmd_valid = 1'b0;
      drive_slaves(2, 0, 0, 0);
      @(negedge clk);
      chk("pre_reset_penable", 32'(penable), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_psel", 32'(psel), 32'd0);
      chk("async_penable", 32'(penable), 32'd0);
      chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("async_paddr", 32'(paddr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
      run_txn(1, 16'h2040, 32'h8888_8888, 0, 32'h0, 0, 0);
      for (int n = 0; n < 30; n++) begin
         int w;
         w = ($urandom_range(0, 5) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 4);
         run_txn(1'($urandom), {4'($urandom_range(0, 7)), 12'($urandom)}, $urandom, w,
                 $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 3));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
